// File: rtl/alu_multicycle.sv
// Handshaked ALU: single-cycle arith/logic/shift/compare, iterative MUL/MULH/DIV/REM.
// Latency: done 1 edge after accept for single-cycle ops, WIDTH+1 edges for iterative ops.
// Backpressure: none queued; start is ignored outside IDLE, busy marks an iterative op in flight.
module alu_multicycle #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SEL_W-1:0] Selector,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] X,
    output logic [7:0]       Flags
);

    localparam int MSB   = WIDTH - 1;
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Opcode map shared with the original 8-bit ALU, zero-extended to SEL_W.
    localparam logic [SEL_W-1:0] OP_ADD  = SEL_W'(8'h01);
    localparam logic [SEL_W-1:0] OP_SUB  = SEL_W'(8'h02);
    localparam logic [SEL_W-1:0] OP_MUL  = SEL_W'(8'h03);
    localparam logic [SEL_W-1:0] OP_DIV  = SEL_W'(8'h04);
    localparam logic [SEL_W-1:0] OP_REM  = SEL_W'(8'h05);
    localparam logic [SEL_W-1:0] OP_AND  = SEL_W'(8'h06);
    localparam logic [SEL_W-1:0] OP_OR   = SEL_W'(8'h07);
    localparam logic [SEL_W-1:0] OP_XOR  = SEL_W'(8'h08);
    localparam logic [SEL_W-1:0] OP_NAND = SEL_W'(8'h09);
    localparam logic [SEL_W-1:0] OP_NOR  = SEL_W'(8'h0A);
    localparam logic [SEL_W-1:0] OP_XNOR = SEL_W'(8'h0B);
    localparam logic [SEL_W-1:0] OP_NOT  = SEL_W'(8'h0C);
    localparam logic [SEL_W-1:0] OP_SHL  = SEL_W'(8'h0D);
    localparam logic [SEL_W-1:0] OP_SHR  = SEL_W'(8'h0E);
    localparam logic [SEL_W-1:0] OP_CMP  = SEL_W'(8'h0F);
    localparam logic [SEL_W-1:0] OP_MULH = SEL_W'(8'h10);
    localparam logic [SEL_W-1:0] OP_MOV  = SEL_W'(8'h80);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched request and iterative working registers.
    // MUL: {hi_q, lo_q} is the partial product, lo_q starts as the multiplier (A).
    // DIV/REM: hi_q is the running remainder, lo_q shifts A out and quotient bits in.
    logic [SEL_W-1:0] op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             op_is_mul;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             div_ok;
    logic             unused_div_bit;

    logic [WIDTH-1:0] res_x;
    logic [7:0]       res_f;
    logic             c_flag;
    logic             o_flag;
    logic             dz_flag;
    logic             std_flags;

    function automatic logic is_iter(input logic [SEL_W-1:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    assign accept    = (state_q == ST_IDLE) && start;
    assign busy      = (state_q == ST_RUN);
    assign op_is_mul = (op_q == OP_MUL) || (op_q == OP_MULH);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: iterative ops spend WIDTH cycles in RUN, everything passes through DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = is_iter(Selector) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // One iteration step of shift-add multiply and restoring division.
    // With B==0 the trial subtraction never borrows, so the quotient fills with ones and the
    // remainder collects A bit by bit, giving the all-ones / A results without a special case.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        div_shift = {hi_q, lo_q[MSB]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_q};
        div_ok    = ~div_diff[WIDTH+1];
    end

    // A successful trial difference is always below the divisor, so bit WIDTH is zero there.
    assign unused_div_bit = div_diff[WIDTH];

    // Result and flag formation from the latched request and the iterative registers.
    always_comb begin
        res_x     = '0;
        res_f     = '0;
        c_flag    = 1'b0;
        o_flag    = 1'b0;
        dz_flag   = 1'b0;
        std_flags = 1'b1;
        case (op_q)
            OP_ADD: begin
                {c_flag, res_x} = {1'b0, a_q} + {1'b0, b_q};
                o_flag = (a_q[MSB] == b_q[MSB]) && (res_x[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                {c_flag, res_x} = {1'b0, a_q} - {1'b0, b_q};
                o_flag = (a_q[MSB] != b_q[MSB]) && (res_x[MSB] != a_q[MSB]);
            end
            OP_MUL: begin
                res_x  = lo_q;
                c_flag = |hi_q;
                o_flag = |hi_q;
            end
            OP_MULH: begin
                res_x  = hi_q;
                c_flag = |hi_q;
                o_flag = |hi_q;
            end
            OP_DIV: begin
                res_x   = lo_q;
                dz_flag = (b_q == '0);
            end
            OP_REM: begin
                res_x   = hi_q;
                dz_flag = (b_q == '0);
            end
            OP_AND:  res_x = a_q & b_q;
            OP_OR:   res_x = a_q | b_q;
            OP_XOR:  res_x = a_q ^ b_q;
            OP_NAND: res_x = ~(a_q & b_q);
            OP_NOR:  res_x = ~(a_q | b_q);
            OP_XNOR: res_x = ~(a_q ^ b_q);
            OP_NOT:  res_x = ~a_q;
            OP_SHL: begin
                res_x  = a_q << b_q[SH_W-1:0];
                c_flag = a_q[MSB];
            end
            OP_SHR: begin
                res_x  = a_q >> b_q[SH_W-1:0];
                c_flag = a_q[0];
            end
            OP_CMP: begin
                // Compare result lives in X[2:0]; the low flags mirror it, nothing else is set.
                std_flags = 1'b0;
                res_x[0]  = (a_q == b_q);
                res_x[1]  = (a_q > b_q);
                res_x[2]  = (a_q < b_q);
                res_f     = {5'b00000, res_x[2:0]};
            end
            OP_MOV: begin
                std_flags = 1'b0;
                res_x     = a_q;
            end
            default: begin
                std_flags = 1'b0;
            end
        endcase
        if (std_flags) begin
            res_f = {1'b0, o_flag, 1'b0, dz_flag, ~^res_x, res_x[MSB], c_flag, (res_x == '0)};
        end
    end

    // Datapath: latch on accept, iterate in RUN, publish X/Flags with a done pulse in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            cnt_q <= '0;
            X     <= '0;
            Flags <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                op_q  <= Selector;
                a_q   <= A;
                b_q   <= B;
                hi_q  <= '0;
                lo_q  <= A;
                cnt_q <= '0;
            end else if (state_q == ST_RUN) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (op_is_mul) begin
                    hi_q <= mul_sum[WIDTH:1];
                    lo_q <= {mul_sum[0], lo_q[MSB:1]};
                end else if (div_ok) begin
                    hi_q <= div_diff[WIDTH-1:0];
                    lo_q <= {lo_q[MSB-1:0], 1'b1};
                end else begin
                    hi_q <= div_shift[WIDTH-1:0];
                    lo_q <= {lo_q[MSB-1:0], 1'b0};
                end
            end else if (state_q == ST_DONE) begin
                X     <= res_x;
                Flags <= res_f;
                done  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: WIDTH=8 instance driven through a scoreboard, plus a WIDTH=16 instance.
// Latency is checked as edges between accept and the edge that raises done.
// Both instances share clk/rst; the 16-bit one is exercised only at the end.
module tb_alu_multicycle;

    localparam logic [7:0] OP_ADD  = 8'h01, OP_SUB  = 8'h02, OP_MUL  = 8'h03, OP_DIV = 8'h04;
    localparam logic [7:0] OP_REM  = 8'h05, OP_AND  = 8'h06, OP_OR   = 8'h07, OP_XOR = 8'h08;
    localparam logic [7:0] OP_NAND = 8'h09, OP_NOR  = 8'h0A, OP_XNOR = 8'h0B, OP_NOT = 8'h0C;
    localparam logic [7:0] OP_SHL  = 8'h0D, OP_SHR  = 8'h0E, OP_CMP  = 8'h0F, OP_MULH = 8'h10;
    localparam logic [7:0] OP_MOV  = 8'h80;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, busy, done;
    logic [7:0] a, b, sel, x, flags;

    logic        start16, busy16, done16;
    logic [15:0] a16, b16, x16;
    logic [7:0]  sel16, flags16;

    alu_multicycle #(.WIDTH(8), .SEL_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .Selector(sel),
        .busy(busy), .done(done), .X(x), .Flags(flags)
    );

    alu_multicycle #(.WIDTH(16), .SEL_W(8)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16), .Selector(sel16),
        .busy(busy16), .done(done16), .X(x16), .Flags(flags16)
    );

    typedef struct {
        int         id;
        logic [7:0] x;
        logic [7:0] f;
        int         lat;
        int         acc;
    } exp_t;

    typedef struct {
        logic [7:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] x;
        logic [7:0] f;
        int         lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    int n_checks = 0;
    int n_pass   = 0;
    int edge_cnt = 0;
    int n_done   = 0;
    logic done_prev = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard consumer: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            n_done++;
            chk("done_not_back_to_back", 32'(done_prev), 32'(0));
            chk("done_has_expected", 32'(sb.size() != 0), 32'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk($sformatf("op%0d_X", e.id), 32'(x), 32'(e.x));
                chk($sformatf("op%0d_Flags", e.id), 32'(flags), 32'(e.f));
                chk($sformatf("op%0d_latency", e.id), edge_cnt - e.acc, e.lat);
            end
        end
        done_prev = done;
    end

    function automatic void model(input logic [7:0] s, aa, bb,
                                  output logic [7:0] ex, output logic [7:0] ef, output int lat);
        logic [8:0]  t;
        logic [15:0] p;
        logic        c, o, dz, std;
        c = 1'b0; o = 1'b0; dz = 1'b0; std = 1'b1; ex = 8'h00; ef = 8'h00; lat = 1;
        case (s)
            OP_ADD: begin
                t = {1'b0, aa} + {1'b0, bb};
                ex = t[7:0]; c = t[8];
                o = (aa[7] == bb[7]) && (ex[7] != aa[7]);
            end
            OP_SUB: begin
                ex = aa - bb; c = (aa < bb);
                o = (aa[7] != bb[7]) && (ex[7] != aa[7]);
            end
            OP_MUL, OP_MULH: begin
                p = {8'h00, aa} * {8'h00, bb};
                ex = (s == OP_MUL) ? p[7:0] : p[15:8];
                c = (p[15:8] != 8'h00); o = c; lat = 9;
            end
            OP_DIV: begin
                lat = 9; dz = (bb == 8'h00);
                ex = dz ? 8'hFF : aa / bb;
            end
            OP_REM: begin
                lat = 9; dz = (bb == 8'h00);
                ex = dz ? aa : aa % bb;
            end
            OP_CMP: begin
                std = 1'b0;
                ex = {5'b00000, aa < bb, aa > bb, aa == bb};
                ef = ex;
            end
            default: std = 1'b0;
        endcase
        if (std) ef = {1'b0, o, 1'b0, dz, ~^ex, ex[7], c, ex == 8'h00};
    endfunction

    task automatic add_vec(input logic [7:0] s, aa, bb, ex, ef, input int lat);
        vec_t v;
        v.sel = s; v.a = aa; v.b = bb; v.x = ex; v.f = ef; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Drive one request, record its expectation at the accepting edge, scramble inputs.
    task automatic send(input int id, input logic [7:0] s, aa, bb, ex, ef, input int lat);
        exp_t e;
        @(negedge clk);
        start = 1'b1; sel = s; a = aa; b = bb;
        @(posedge clk); #1;
        e.id = id; e.x = ex; e.f = ef; e.lat = lat; e.acc = edge_cnt;
        sb.push_back(e);
        start = 1'b0; sel = 8'($urandom); a = 8'($urandom); b = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        chk("drain_in_budget", 32'(sb.size() == 0), 32'(1));
        sb.delete();
    endtask

    task automatic run16(input logic [7:0] s, input logic [15:0] aa, bb,
                         output logic [15:0] rx, output logic [7:0] rf, output int lat);
        @(negedge clk);
        start16 = 1'b1; sel16 = s; a16 = aa; b16 = bb;
        @(posedge clk); #1;
        start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        lat = 0;
        while (!done16 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        rx = x16; rf = flags16;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rx16;
        logic [7:0]  rf16;
        int          lat16;
        int          done_before;

        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; sel = 8'h00;
        start16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; sel16 = 8'h00;

        //          sel      A      B      X      Flags  lat
        add_vec(OP_ADD,  8'hFF, 8'h01, 8'h00, 8'h0B, 1);
        add_vec(OP_ADD,  8'h7F, 8'h01, 8'h80, 8'h44, 1);
        add_vec(OP_SUB,  8'h03, 8'h05, 8'hFE, 8'h06, 1);
        add_vec(OP_SUB,  8'h80, 8'h01, 8'h7F, 8'h40, 1);
        add_vec(OP_MUL,  8'h10, 8'h10, 8'h00, 8'h4B, 9);
        add_vec(OP_MULH, 8'h10, 8'h10, 8'h01, 8'h42, 9);
        add_vec(OP_DIV,  8'hC8, 8'h07, 8'h1C, 8'h00, 9);
        add_vec(OP_REM,  8'hC8, 8'h07, 8'h04, 8'h00, 9);
        add_vec(OP_DIV,  8'h05, 8'h00, 8'hFF, 8'h1C, 9);
        add_vec(OP_REM,  8'h05, 8'h00, 8'h05, 8'h18, 9);
        add_vec(OP_AND,  8'hF0, 8'h3C, 8'h30, 8'h08, 1);
        add_vec(OP_OR,   8'hF0, 8'h0F, 8'hFF, 8'h0C, 1);
        add_vec(OP_XOR,  8'hAA, 8'hAA, 8'h00, 8'h09, 1);
        add_vec(OP_NAND, 8'hF0, 8'h3C, 8'hCF, 8'h0C, 1);
        add_vec(OP_NOR,  8'h0F, 8'h30, 8'hC0, 8'h0C, 1);
        add_vec(OP_XNOR, 8'h0F, 8'h33, 8'hC3, 8'h0C, 1);
        add_vec(OP_NOT,  8'h5A, 8'hFF, 8'hA5, 8'h0C, 1);
        add_vec(OP_SHL,  8'h81, 8'h0B, 8'h08, 8'h02, 1);
        add_vec(OP_SHR,  8'h81, 8'h01, 8'h40, 8'h02, 1);
        add_vec(OP_CMP,  8'h05, 8'h09, 8'h04, 8'h04, 1);
        add_vec(OP_CMP,  8'h09, 8'h09, 8'h01, 8'h01, 1);
        add_vec(OP_CMP,  8'h0A, 8'h03, 8'h02, 8'h02, 1);
        add_vec(OP_MOV,  8'h00, 8'h55, 8'h00, 8'h00, 1);
        add_vec(OP_MOV,  8'h9C, 8'h00, 8'h9C, 8'h00, 1);
        add_vec(8'h11,   8'h12, 8'h34, 8'h00, 8'h00, 1);
        add_vec(8'h00,   8'hFF, 8'hFF, 8'h00, 8'h00, 1);
        add_vec(OP_DIV,  8'hFF, 8'h10, 8'h0F, 8'h08, 9);
        add_vec(OP_REM,  8'hFF, 8'h10, 8'h0F, 8'h08, 9);
        add_vec(OP_MUL,  8'h0F, 8'h0D, 8'hC3, 8'h0C, 9);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",  32'(busy),  32'(0));
        chk("reset_done",  32'(done),  32'(0));
        chk("reset_X",     32'(x),     32'(0));
        chk("reset_Flags", 32'(flags), 32'(0));
        chk("reset_busy16", 32'(busy16), 32'(0));
        chk("reset_X16",    32'(x16),    32'(0));
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < vecs.size(); i++) begin
            send(i, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].x, vecs[i].f, vecs[i].lat);
            drain();
        end

        // Busy window of an iterative op
        send(100, OP_MUL, 8'h0F, 8'h0D, 8'hC3, 8'h0C, 9);
        chk("busy_after_accept", 32'(busy), 32'(1));
        repeat (7) @(posedge clk);
        #1;
        chk("busy_last_iter", 32'(busy), 32'(1));
        @(posedge clk); #1;
        chk("busy_dropped", 32'(busy), 32'(0));
        chk("done_not_early", 32'(done), 32'(0));
        drain();

        // start pulsed while busy with different operands is ignored
        send(101, OP_DIV, 8'hC8, 8'h07, 8'h1C, 8'h00, 9);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; sel = OP_MUL; a = 8'h33; b = 8'h44;
        repeat (3) @(negedge clk);
        start = 1'b0;
        drain();
        done_before = n_done;
        repeat (12) @(posedge clk);
        #1;
        chk("ignored_start_no_extra_done", n_done, done_before);
        chk("ignored_start_idle", 32'(busy), 32'(0));

        // Give X/Flags nonzero content, then abort a DIV with rst
        send(102, OP_ADD, 8'hFF, 8'h01, 8'h00, 8'h0B, 1);
        drain();
        send(103, OP_SHR, 8'h81, 8'h01, 8'h40, 8'h02, 1);
        drain();
        @(negedge clk);
        start = 1'b1; sel = OP_DIV; a = 8'hFF; b = 8'h03;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_before_abort", 32'(busy), 32'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy",  32'(busy),  32'(0));
        chk("abort_done",  32'(done),  32'(0));
        chk("abort_X",     32'(x),     32'(0));
        chk("abort_Flags", 32'(flags), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        done_before = n_done;
        repeat (15) @(posedge clk);
        #1;
        chk("abort_no_done", n_done, done_before);
        send(104, OP_ADD, 8'h7F, 8'h01, 8'h80, 8'h44, 1);
        drain();

        // Random arithmetic against the reference model
        for (int i = 0; i < 24; i++) begin
            logic [7:0] s, aa, bb, ex, ef;
            int lat;
            case ($urandom_range(0, 6))
                0: s = OP_ADD;
                1: s = OP_SUB;
                2: s = OP_MUL;
                3: s = OP_MULH;
                4: s = OP_DIV;
                5: s = OP_REM;
                default: s = OP_CMP;
            endcase
            aa = 8'($urandom);
            bb = (i % 5 == 0) ? 8'h00 : 8'($urandom);
            model(s, aa, bb, ex, ef, lat);
            send(200 + i, s, aa, bb, ex, ef, lat);
            drain();
        end

        // WIDTH=16 instance
        run16(OP_MUL, 16'h1234, 16'h0100, rx16, rf16, lat16);
        chk("w16_mul_X", 32'(rx16), 32'h3400);
        chk("w16_mul_Flags", 32'(rf16), 32'h42);
        chk("w16_mul_latency", lat16, 17);
        run16(OP_MULH, 16'h1234, 16'h0100, rx16, rf16, lat16);
        chk("w16_mulh_X", 32'(rx16), 32'h0012);
        chk("w16_mulh_Flags", 32'(rf16), 32'h4A);
        chk("w16_mulh_latency", lat16, 17);
        run16(OP_CMP, 16'h0005, 16'h0009, rx16, rf16, lat16);
        chk("w16_cmp_X", 32'(rx16), 32'h0004);
        chk("w16_cmp_Flags", 32'(rf16), 32'h04);
        chk("w16_cmp_latency", lat16, 1);

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
